// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit: forwarding selects and memory FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones instead of wrapping.
// Latency: one cycle from inc to the visible count.
// Backpressure: none; inc is sampled every cycle, rst clears synchronously.
module hazard_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Count up on inc until every bit is set, then hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: forwarding selects, load-use bubbles, redirect flushes, memory-wait freeze.
// Latency: controls are combinational same cycle; FSM state and counters update on the next edge.
// Backpressure: a pending data-memory access freezes the whole pipe until MemReadyM.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int PCSRC_W = 2,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REG_AW-1:0]  Rs1D,
    input  logic [REG_AW-1:0]  Rs2D,
    input  logic [REG_AW-1:0]  Rs1E,
    input  logic [REG_AW-1:0]  Rs2E,
    input  logic [REG_AW-1:0]  RdE,
    input  logic [REG_AW-1:0]  RdM,
    input  logic [REG_AW-1:0]  RdW,
    input  logic               RegWriteM,
    input  logic               RegWriteW,
    input  logic               ResultSrcE0,
    input  logic [PCSRC_W-1:0] PCSrcE,
    input  logic               MemReqM,
    input  logic               MemReadyM,
    output logic [1:0]         ForwardAE,
    output logic [1:0]         ForwardBE,
    output logic               PCEn,
    output logic               FEn,
    output logic               DEn,
    output logic               EEn,
    output logic               MEn,
    output logic               Frst,
    output logic               Drst,
    output logic               MemIssueM,
    output logic [CNT_W-1:0]   StallCnt,
    output logic [CNT_W-1:0]   FlushCnt,
    output logic [CNT_W-1:0]   LoadUseCnt
);

    mem_state_t state;
    logic       mem_wait;
    logic       redirect;
    logic       lw_stall;
    logic       stall_inc;
    logic       flush_inc;
    logic       lu_inc;

    // M wins over W because it holds the younger value; x0 is hard-wired zero and never forwarded.
    function automatic fwd_sel_t fwd_pick(input logic [REG_AW-1:0] rs,
                                          input logic [REG_AW-1:0] rd_m,
                                          input logic              we_m,
                                          input logic [REG_AW-1:0] rd_w,
                                          input logic              we_w);
        if (we_m && (rd_m != '0) && (rd_m == rs)) begin
            return FWD_M;
        end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    assign redirect = (PCSrcE != '0);
    assign lw_stall = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_wait = ((state == IDLE) && MemReqM && !MemReadyM) ||
                      ((state == WAIT) && !MemReadyM);

    // Only the hazard that actually wins the priority chain is counted.
    assign stall_inc = !rst && (mem_wait || (!redirect && lw_stall));
    assign flush_inc = !rst && !mem_wait && redirect;
    assign lu_inc    = !rst && !mem_wait && !redirect && lw_stall;

    // Memory handshake: issue once from IDLE, park in WAIT until the data memory completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (MemReqM && !MemReadyM) state <= WAIT;
                WAIT:    if (MemReadyM)             state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Priority chain: reset, memory freeze, redirect flush, load-use bubble, free-run.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        PCEn      = 1'b1;
        FEn       = 1'b1;
        DEn       = 1'b1;
        EEn       = 1'b1;
        MEn       = 1'b1;
        Frst      = 1'b0;
        Drst      = 1'b0;
        MemIssueM = 1'b0;
        if (rst) begin
            Frst = 1'b1;
            Drst = 1'b1;
        end else begin
            ForwardAE = fwd_pick(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
            ForwardBE = fwd_pick(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
            MemIssueM = (state == IDLE) && MemReqM;
            if (mem_wait) begin
                PCEn = 1'b0;
                FEn  = 1'b0;
                DEn  = 1'b0;
                EEn  = 1'b0;
                MEn  = 1'b0;
            end else if (redirect) begin
                Frst = 1'b1;
                Drst = 1'b1;
            end else if (lw_stall) begin
                PCEn = 1'b0;
                FEn  = 1'b0;
                Drst = 1'b1;
            end
        end
    end

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (StallCnt)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (FlushCnt)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk (clk),
        .rst (rst),
        .inc (lu_inc),
        .cnt (LoadUseCnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with a behavioural model checked every cycle.
// Latency: model expects combinational controls and next-cycle counter updates.
// Backpressure: stimulus holds MemReqM through memory waits.
module tb_hazard_unit;

    localparam int CW  = 3;
    localparam int SAT = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, ResultSrcE0;
    logic [1:0] PCSrcE;
    logic       MemReqM, MemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       PCEn, FEn, DEn, EEn, MEn, Frst, Drst, MemIssueM;
    logic [CW-1:0] StallCnt, FlushCnt, LoadUseCnt;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    hazard_unit #(.REG_AW(5), .PCSRC_W(2), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .PCEn(PCEn), .FEn(FEn), .DEn(DEn), .EEn(EEn), .MEn(MEn),
        .Frst(Frst), .Drst(Drst), .MemIssueM(MemIssueM),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt), .LoadUseCnt(LoadUseCnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    int m_stall = 0, m_flush = 0, m_lu = 0;
    bit m_busy = 1'b0;   // an issued access is still outstanding

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    bit e_wait, e_redir, e_lw;
    logic [4:0] e_en;          // {PC,F,D,E,M}
    logic [1:0] e_fl;          // {Frst,Drst}
    logic       e_iss;
    logic [1:0] e_fa, e_fb;

    always @(negedge clk) begin
        if (chk_en) begin
            e_wait  = m_busy ? !MemReadyM : (MemReqM && !MemReadyM);
            e_redir = (PCSrcE != 0);
            e_lw    = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
            if (rst) begin
                e_fa = 2'b00; e_fb = 2'b00; e_iss = 1'b0;
                e_en = 5'b11111; e_fl = 2'b11;
            end else begin
                e_fa  = exp_fwd(Rs1E);
                e_fb  = exp_fwd(Rs2E);
                e_iss = !m_busy && MemReqM;
                if (e_wait)       begin e_en = 5'b00000; e_fl = 2'b00; end
                else if (e_redir) begin e_en = 5'b11111; e_fl = 2'b11; end
                else if (e_lw)    begin e_en = 5'b00111; e_fl = 2'b01; end
                else              begin e_en = 5'b11111; e_fl = 2'b00; end
            end
            chk("m_ForwardAE", ForwardAE, e_fa);
            chk("m_ForwardBE", ForwardBE, e_fb);
            chk("m_enables", {PCEn, FEn, DEn, EEn, MEn}, e_en);
            chk("m_flushes", {Frst, Drst}, e_fl);
            chk("m_MemIssueM", MemIssueM, e_iss);
            chk("m_StallCnt", StallCnt, m_stall);
            chk("m_FlushCnt", FlushCnt, m_flush);
            chk("m_LoadUseCnt", LoadUseCnt, m_lu);
            if (rst) begin
                m_stall = 0; m_flush = 0; m_lu = 0; m_busy = 1'b0;
            end else begin
                if (e_wait || (!e_redir && e_lw)) m_stall = sat_inc(m_stall);
                if (!e_wait && e_redir)           m_flush = sat_inc(m_flush);
                if (!e_wait && !e_redir && e_lw)  m_lu    = sat_inc(m_lu);
                m_busy = m_busy ? !MemReadyM : (MemReqM && !MemReadyM);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic do_reset();
        clr(); rst = 1'b1; #2; cyc();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset masks forwarding and memory issue.
        clr(); rst = 1'b1; RdM = 5; RegWriteM = 1; Rs1E = 5; MemReqM = 1;
        #2;
        chk("rst_fwd", ForwardAE, 2'b00);
        chk("rst_en", {PCEn, FEn, DEn, EEn, MEn}, 5'b11111);
        chk("rst_flush", {Frst, Drst}, 2'b11);
        chk("rst_issue", MemIssueM, 1'b0);
        cyc(); chk_en = 1'b1;
        cyc();
        clr(); rst = 1'b0; #2;
        chk("rst_cnt", {StallCnt, FlushCnt, LoadUseCnt}, 9'd0);
        cyc();

        // Forwarding priority and x0.
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 5; #2;
        chk("fwd_m_prio", ForwardAE, 2'b10);
        cyc();
        RegWriteM = 0; #2;
        chk("fwd_w", ForwardBE, 2'b01);
        cyc();
        clr(); RdM = 0; RegWriteM = 1; Rs1E = 0; RdW = 0; RegWriteW = 1; #2;
        chk("fwd_x0", ForwardAE, 2'b00);
        cyc();

        // Load-use: one bubble.
        clr(); ResultSrcE0 = 1; RdE = 7; Rs2D = 7; #2;
        chk("lu_en", {PCEn, FEn, DEn, EEn, MEn}, 5'b00111);
        chk("lu_flush", {Frst, Drst}, 2'b01);
        cyc();
        clr(); #2;
        chk("lu_cnt", LoadUseCnt, 3'd1);
        chk("lu_stall", StallCnt, 3'd1);
        chk("lu_released", PCEn, 1'b1);
        cyc();
        // Load writing x0 never stalls.
        ResultSrcE0 = 1; RdE = 0; Rs1D = 0; #2;
        chk("lu_x0", PCEn, 1'b1);
        cyc();

        // Redirect overrides load-use.
        clr(); PCSrcE = 2'b01; ResultSrcE0 = 1; RdE = 7; Rs1D = 7; #2;
        chk("rd_en", {PCEn, FEn, DEn, EEn, MEn}, 5'b11111);
        chk("rd_flush", {Frst, Drst}, 2'b11);
        cyc();
        clr(); #2;
        chk("rd_flushcnt", FlushCnt, 3'd1);
        chk("rd_lucnt", LoadUseCnt, 3'd1);
        cyc();

        // Memory wait: three frozen cycles, single issue.
        do_reset();
        MemReqM = 1; #2;
        chk("mw_issue", MemIssueM, 1'b1);
        chk("mw_frz0", {PCEn, FEn, DEn, EEn, MEn}, 5'b00000);
        cyc();
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("mw_noreissue", MemIssueM, 1'b0);
            chk("mw_frz", {PCEn, FEn, DEn, EEn, MEn}, 5'b00000);
            cyc();
        end
        MemReadyM = 1; #2;
        chk("mw_release", {PCEn, FEn, DEn, EEn, MEn}, 5'b11111);
        cyc();
        clr(); #2;
        chk("mw_stallcnt", StallCnt, 3'd3);
        chk("mw_idle", MemIssueM, 1'b0);
        cyc();

        // Zero-stall access completing in the issue cycle.
        MemReqM = 1; MemReadyM = 1; #2;
        chk("mz_issue", MemIssueM, 1'b1);
        chk("mz_en", PCEn, 1'b1);
        cyc();
        clr(); #2;
        chk("mz_stallcnt", StallCnt, 3'd3);
        cyc();

        // Redirect held off by memory wait; request drops mid-wait.
        do_reset();
        MemReqM = 1; cyc();
        MemReqM = 0; PCSrcE = 2'b10; #2;
        chk("rw_noflush", {Frst, Drst}, 2'b00);
        chk("rw_frz", PCEn, 1'b0);
        cyc();
        MemReadyM = 1; #2;
        chk("rw_flush", {Frst, Drst}, 2'b11);
        cyc();
        clr(); #2;
        chk("rw_flushcnt", FlushCnt, 3'd1);
        chk("rw_stallcnt", StallCnt, 3'd2);
        cyc();

        // Saturation: nine load-use stalls.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            ResultSrcE0 = 1; RdE = 3; Rs1D = 3; cyc();
        end
        clr(); #2;
        chk("sat_lu", LoadUseCnt, 3'd7);
        chk("sat_stall", StallCnt, 3'd7);
        cyc();

        // Reset mid-wait abandons the access.
        MemReqM = 1; cyc(); cyc();
        rst = 1'b1; #2;
        chk("rw_rst_issue", MemIssueM, 1'b0);
        cyc();
        rst = 1'b0; MemReqM = 0; #2;
        chk("rw_rst_cnt", {StallCnt, FlushCnt, LoadUseCnt}, 9'd0);
        chk("rw_rst_idle", PCEn, 1'b1);
        cyc();
        MemReqM = 1; MemReadyM = 1; #2;
        chk("rw_rst_reissue", MemIssueM, 1'b1);
        cyc();
        clr(); cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised hazard unit for the pipelined RISC-V core. It generalises the branch-flush-only control: data forwarding from M and W, load-use stall insertion, control-hazard flush on taken branches/jumps resolved in E, a multi-cycle data-memory wait FSM, and saturating hazard performance counters. It sits beside the five-stage datapath and drives every pipeline-register enable, flush and forwarding mux select.

## Interface
Parameters:
- REG_AW, 5, register-address width
- PCSRC_W, 2, width of PCSrcE (0 = sequential PC)
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- Rs1D, Rs2D  in  REG_AW  source registers in D
- Rs1E, Rs2E  in  REG_AW  source registers in E
- RdE, RdM, RdW  in  REG_AW  destination registers
- RegWriteM, RegWriteW  in  1  write-back valid in M / W
- ResultSrcE0  in  1  instruction in E is a load
- PCSrcE  in  PCSRC_W  non-zero = redirect taken in E
- MemReqM  in  1  load/store in M
- MemReadyM  in  1  data memory completion
- ForwardAE, ForwardBE  out  2  00 register file, 10 from M, 01 from W
- PCEn, FEn, DEn, EEn, MEn  out  1  enables: PC, F/D, D/E, E/M, M/W registers
- Frst, Drst  out  1  flush F/D, flush D/E (synchronous clear in the datapath)
- MemIssueM  out  1  one-cycle memory request strobe
- StallCnt, FlushCnt, LoadUseCnt  out  CNT_W  performance counters

## Operation
- Forwarding (per operand, A shown): RegWriteM && RdM!=0 && RdM==Rs1E -> 10; else RegWriteW && RdW!=0 && RdW==Rs1E -> 01; else 00. M has priority over W; x0 never forwarded.
- Load-use: lwStall = ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- Control: redirect = (PCSrcE != 0).
- Memory FSM, states IDLE, WAIT:
  - IDLE: MemReqM -> MemIssueM=1; if MemReadyM same cycle stay IDLE, else -> WAIT.
  - WAIT: MemIssueM=0; memWait=1 while !MemReadyM; MemReadyM -> IDLE, memWait=0 in that cycle.
  - memWait = (IDLE && MemReqM && !MemReadyM) || (WAIT && !MemReadyM).
- Priority, highest first:
  - rst: all enables 1, Frst=Drst=1, forwards 00, MemIssueM 0.
  - memWait: all enables 0, Frst=Drst=0 (whole pipe frozen; pending redirect or load-use re-evaluated after release).
  - redirect: all enables 1, Frst=Drst=1; lwStall ignored (dependent instruction is flushed).
  - lwStall: PCEn=FEn=0, DEn=EEn=MEn=1, Drst=1 (bubble into E), Frst=0.
  - none: all enables 1, flushes 0.
- Counters, each saturating at 2^CNT_W-1, never wrapping: StallCnt +1 per cycle memWait||lwStall (taken); FlushCnt +1 per cycle redirect is taken; LoadUseCnt +1 per cycle lwStall is taken. "Taken" means not masked by a higher priority.

## Timing
- Forwarding, enables, flushes, MemIssueM: combinational from inputs and FSM state, same cycle.
- FSM state and counters update on rising clk; counter values visible the cycle after the event.
- Reset: state IDLE, all counters 0; reset mid-WAIT abandons the access (MemIssueM not reissued unless MemReqM persists after reset).
- Load-use costs exactly one bubble; redirect costs two flushed instructions.
- Memory completion with MemReadyM in the issue cycle costs zero stall cycles.
- MemReqM held across WAIT does not produce a second MemIssueM; MemReqM dropping in WAIT is a protocol error, FSM still waits for MemReadyM.

## Structure
- Shared package hazard_pkg: fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10), mem_state_t (IDLE, WAIT).
- One sub-module: hazard_sat_counter (CNT_W, increment enable, sync reset), instantiated three times.

## Test plan
- Forward: RdM=5 RegWriteM=1, RdW=5 RegWriteW=1, Rs1E=5 -> ForwardAE=10; RdM=0 RegWriteM=1 Rs1E=0 -> 00.
- Load-use: ResultSrcE0=1 RdE=7 Rs2D=7 -> PCEn=FEn=0, Drst=1 for one cycle; LoadUseCnt=1, StallCnt=1 next cycle.
- Redirect plus load-use same cycle: PCSrcE=01, lwStall true -> Frst=Drst=1, all enables 1, FlushCnt +1, LoadUseCnt unchanged.
- Memory wait: MemReqM=1, MemReadyM low 3 cycles then high -> MemIssueM single pulse, all enables 0 for 3 cycles, StallCnt=3, FSM back in IDLE.
- Redirect during memory wait: PCSrcE=10 while WAIT -> no flush until MemReadyM; flush asserted in the release cycle, FlushCnt +1 once.
- Saturation and reset: CNT_W=3, 9 load-use stalls -> LoadUseCnt holds 7; rst mid-WAIT -> counters 0, state IDLE next cycle.
